// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_pipe
//  Purpose  : Pipelined two's-complement adder/subtractor. The operands are
//             split into STAGES chunks of ceil(WIDTH/STAGES) bits; each stage
//             adds one chunk using the carry registered by the stage before.
//             Higher operand chunks ride forward in skew registers and
//             finished low result chunks ride forward in deskew registers.
//             The whole pipeline advances together under a valid/ready
//             handshake.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready, x, y, sub   - operation input (sub=1: x-y)
//             out_valid/out_ready            - result handshake
//             sum, cout, ovf                 - result, carry (1 = no borrow
//                                              on subtract), signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
  parameter int WIDTH  = 37,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_cw   = (WIDTH + STAGES - 1) / STAGES;
  // Operands are zero-padded to a whole number of chunks so every stage has
  // the same chunk width; the padding bits of x and the inverted y are zero,
  // so the carry out of bit WIDTH-1 lands in padded sum bit WIDTH.
  localparam int c_pw   = c_cw * STAGES;
  localparam int c_last = STAGES - 1;

  logic             w_advance;
  logic [WIDTH-1:0] w_yinv;
  logic [c_pw-1:0]  w_xpad;
  logic [c_pw-1:0]  w_ypad;
  logic [c_pw:0]    w_full;
  logic             w_unused_top;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  // Subtract is x + ~y + 1; the +1 enters as the stage-0 carry-in.
  assign w_yinv = y ^ {WIDTH{sub}};

  always_comb begin
    w_xpad              = '0;
    w_ypad              = '0;
    w_xpad[WIDTH-1:0]   = x;
    w_ypad[WIDTH-1:0]   = w_yinv;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            r_v;
    logic            r_c;
    logic            r_xmsb;
    logic            r_ymsb;
    logic [c_pw-1:0] r_x;
    logic [c_pw-1:0] r_y;
    logic [c_pw-1:0] r_s;

    logic            w_vin;
    logic            w_cin;
    logic            w_xmsb_in;
    logic            w_ymsb_in;
    logic [c_pw-1:0] w_xin;
    logic [c_pw-1:0] w_yin;
    logic [c_pw-1:0] w_sin;
    logic [c_pw-1:0] w_snext;
    logic [c_cw:0]   w_chunk;
    logic            w_unused_ops;

    if (k == 0) begin : g_head
      assign w_vin     = in_valid;
      assign w_cin     = sub;
      assign w_xin     = w_xpad;
      assign w_yin     = w_ypad;
      assign w_sin     = '0;
      assign w_xmsb_in = x[WIDTH-1];
      assign w_ymsb_in = w_yinv[WIDTH-1];
    end else begin : g_body
      assign w_vin     = g_stage[k-1].r_v;
      assign w_cin     = g_stage[k-1].r_c;
      assign w_xin     = g_stage[k-1].r_x;
      assign w_yin     = g_stage[k-1].r_y;
      assign w_sin     = g_stage[k-1].r_s;
      assign w_xmsb_in = g_stage[k-1].r_xmsb;
      assign w_ymsb_in = g_stage[k-1].r_ymsb;
    end

    assign w_chunk = {1'b0, w_xin[k*c_cw +: c_cw]}
                   + {1'b0, w_yin[k*c_cw +: c_cw]}
                   + {{c_cw{1'b0}}, w_cin};

    always_comb begin
      w_snext                  = w_sin;
      w_snext[k*c_cw +: c_cw]  = w_chunk[c_cw-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_c    <= 1'b0;
        r_xmsb <= 1'b0;
        r_ymsb <= 1'b0;
        r_x    <= '0;
        r_y    <= '0;
        r_s    <= '0;
      end else if (w_advance) begin
        r_v    <= w_vin;
        r_c    <= w_chunk[c_cw];
        r_xmsb <= w_xmsb_in;
        r_ymsb <= w_ymsb_in;
        r_x    <= w_xin;
        r_y    <= w_yin;
        r_s    <= w_snext;
      end
    end

    // Operand chunks at or below this stage are already consumed, and the
    // last stage's operand copy has no reader; synthesis prunes them.
    assign w_unused_ops = ^{r_x, r_y};
  end

  // Bit WIDTH of {carry, padded sum} is the carry out of bit WIDTH-1,
  // whether or not padding exists.
  assign w_full       = {g_stage[c_last].r_c, g_stage[c_last].r_s};
  assign w_unused_top = ^w_full;

  assign out_valid = g_stage[c_last].r_v;
  assign sum       = w_full[WIDTH-1:0];
  assign cout      = w_full[WIDTH];
  assign ovf       = (g_stage[c_last].r_xmsb == g_stage[c_last].r_ymsb)
                   & (w_full[WIDTH-1] != g_stage[c_last].r_xmsb);

endmodule
`default_nettype wire

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 37: operand and result width in bits; legal range 2..128.
REQ-002 Parameter STAGES, default 3: pipeline depth; legal range 1..WIDTH; operand split into STAGES chunks of CW = ceil(WIDTH/STAGES) bits, last chunk holds the remainder.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  x, y, sub carry a new operation this cycle.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 x  input  WIDTH  first operand.
REQ-008 y  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = x+y, 1 = x-y.
REQ-010 out_valid  output  1  sum/cout/ovf hold a completed result.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-015 Accept = in_valid & in_ready; Deliver = out_valid & out_ready.
REQ-016 Subtract computed as x + ~y + 1 (carry-in = sub); sum, cout, ovf identical to full-width combinational evaluation.
REQ-017 Stage k (0..STAGES-1) adds chunk k of the operands with the carry registered from stage k-1; higher chunks of operands travel through skew registers, lower result chunks through deskew registers.
REQ-018 Latency: an operation accepted in cycle n has out_valid=1 with its result in cycle n+STAGES when no stall occurs.
REQ-019 Each stage holds a valid bit; pipeline advances as a whole when advance = ~out_valid | out_ready.
REQ-020 in_ready = advance (combinational); when advance=0 every stage register, including valid bits, holds.
REQ-021 Results delivered in acceptance order; no operation dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 Throughput one operation per cycle while out_ready=1; bubbles (in_valid=0) propagate as out_valid=0 slots.
REQ-023 While out_valid=1 and out_ready=0, sum/cout/ovf/out_valid stable.
REQ-024 ovf = (x[W-1] == y'[W-1]) & (sum[W-1] != x[W-1]), y' = y^{WIDTH{sub}}.
REQ-025 Simultaneous Accept and Deliver in one cycle legal: both occur, occupancy unchanged.
REQ-026 in_valid=1 while in_ready=0: operation not taken; source must hold it.
REQ-027 STAGES=1: single registered full-width adder, latency 1, same handshake.

Reset
REQ-028 rst_n=0 asynchronously clears all valid bits; out_valid=0, sum=0, cout=0, ovf=0 immediately.
REQ-029 Data/skew registers cleared on reset as well; in-flight operations discarded, none emerge after release.
REQ-030 in_ready=1 in the first cycle after rst_n deasserts; first accepted operation appears STAGES cycles later.

Verification (WIDTH=37, STAGES=3, CW=13)
REQ-031 Add: x=58, y=100, sub=0, out_ready=1 -> 3 cycles later sum=158, cout=0, ovf=0.
REQ-032 Subtract: x=100,y=58,sub=1 -> sum=42,cout=1; next op x=58,y=100,sub=1 -> sum=137438953430,cout=0,ovf=0.
REQ-033 Carry chain across chunks: x=8191,y=1 -> sum=8192; x=137438953471,y=1 -> sum=0,cout=1,ovf=0; x=68719476735,y=1 -> sum=68719476736,cout=0,ovf=1.
REQ-034 Stream 8 back-to-back ops (58+100, 580+60000, 500000000+55000, 1000000000+1600000000, 8000+100, 880000+4400, 55+10, 35+65), out_ready=0 for cycles 5-6 -> in_ready=0 during stall, outputs held, results 158, 60580, 500055000, 2600000000, 8100, 884400, 65, 100 in order.
REQ-035 Reset mid-stream: accept 2 ops, drop rst_n for one cycle before completion -> out_valid=0 immediately, no result for those ops after release; next op x=35,y=65 -> sum=100 after 3 cycles.
REQ-036 Parameter sweep: WIDTH in {8,37,64}, STAGES in {1,2,3,WIDTH} with random operands, sub and random out_ready -> every result matches full-width reference model including cout/ovf.
